// File: rtl/iob_gpio_edge_pkg.sv
// Shared register map, CTRL bit positions and reset values for the GPIO edge peripheral.
package iob_gpio_edge_pkg;

    typedef enum logic [2:0] {
        REG_IN0   = 3'd0,
        REG_IN1   = 3'd1,
        REG_OUT   = 3'd2,
        REG_MASK0 = 3'd3,
        REG_MASK1 = 3'd4,
        REG_STAT0 = 3'd5,
        REG_STAT1 = 3'd6,
        REG_CTRL  = 3'd7
    } reg_addr_e;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_POL    = 1;
    localparam int CTRL_W      = 2;

    localparam logic [CTRL_W-1:0] CTRL_RST_VAL = '0;

endpackage

// File: rtl/iob_gpio_edge_det.sv
// Per-bus input synchronizer with a one-cycle history flop and polarity-selected edge vector.
module iob_gpio_edge_det #(
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_in,
    input  logic         pol,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] edge_vec
);

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= data_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // pol=0 selects rising edges, pol=1 falling edges
    assign edge_vec = pol ? (~sync_out & prev_q) : (sync_out & ~prev_q);

endmodule

// File: rtl/iob_gpio_edge.sv
// Native-bus GPIO peripheral: register file, single-cycle response handshake,
// sticky W1C edge status and a registered level interrupt.
module iob_gpio_edge
    import iob_gpio_edge_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 3,
    parameter int GPIO_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    input  logic [GPIO_W-1:0]   gpio_input,
    input  logic [GPIO_W-1:0]   gpio_input2,
    output logic [GPIO_W-1:0]   gpio_output,
    output logic                irq
);

    localparam int STRB_W = DATA_W / 8;

    logic [GPIO_W-1:0] in0, in1, edge0, edge1;
    logic [GPIO_W-1:0] out_q, mask0_q, mask1_q, stat0_q, stat1_q;
    logic [CTRL_W-1:0] ctrl_q;

    logic              accept, wr_en;
    reg_addr_e         reg_sel;
    logic [DATA_W-1:0] lane_mask, rd_mux;
    logic [GPIO_W-1:0] wmask, wdat, clr0, clr1;

    iob_gpio_edge_det #(.W(GPIO_W), .SYNC_STAGES(SYNC_STAGES)) u_det0 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (gpio_input),
        .pol      (ctrl_q[CTRL_POL]),
        .sync_out (in0),
        .edge_vec (edge0)
    );

    iob_gpio_edge_det #(.W(GPIO_W), .SYNC_STAGES(SYNC_STAGES)) u_det1 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (gpio_input2),
        .pol      (ctrl_q[CTRL_POL]),
        .sync_out (in1),
        .edge_vec (edge1)
    );

    // A valid seen while the response is on the bus belongs to the finished request
    assign accept  = valid & ~ready;
    assign wr_en   = accept & (|wstrb);
    assign reg_sel = reg_addr_e'(address);

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            lane_mask[b*8 +: 8] = {8{wstrb[b]}};
        end
    end

    assign wmask = lane_mask[GPIO_W-1:0];
    assign wdat  = wdata[GPIO_W-1:0];

    function automatic logic [GPIO_W-1:0] merge_lanes(
        input logic [GPIO_W-1:0] old_val,
        input logic [GPIO_W-1:0] new_val,
        input logic [GPIO_W-1:0] lanes
    );
        return (old_val & ~lanes) | (new_val & lanes);
    endfunction

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_IN0:   rd_mux[GPIO_W-1:0] = in0;
            REG_IN1:   rd_mux[GPIO_W-1:0] = in1;
            REG_OUT:   rd_mux[GPIO_W-1:0] = out_q;
            REG_MASK0: rd_mux[GPIO_W-1:0] = mask0_q;
            REG_MASK1: rd_mux[GPIO_W-1:0] = mask1_q;
            REG_STAT0: rd_mux[GPIO_W-1:0] = stat0_q;
            REG_STAT1: rd_mux[GPIO_W-1:0] = stat1_q;
            REG_CTRL:  rd_mux[CTRL_W-1:0] = ctrl_q;
            default:   rd_mux = '0;
        endcase
    end

    assign clr0 = (wr_en && reg_sel == REG_STAT0) ? (wdat & wmask) : '0;
    assign clr1 = (wr_en && reg_sel == REG_STAT1) ? (wdat & wmask) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready   <= 1'b0;
            rdata   <= '0;
            out_q   <= '0;
            mask0_q <= '0;
            mask1_q <= '0;
            stat0_q <= '0;
            stat1_q <= '0;
            ctrl_q  <= CTRL_RST_VAL;
            irq     <= 1'b0;
        end else begin
            ready <= accept;
            if (accept) begin
                rdata <= rd_mux;
            end
            if (wr_en && reg_sel == REG_OUT) begin
                out_q <= merge_lanes(out_q, wdat, wmask);
            end
            if (wr_en && reg_sel == REG_MASK0) begin
                mask0_q <= merge_lanes(mask0_q, wdat, wmask);
            end
            if (wr_en && reg_sel == REG_MASK1) begin
                mask1_q <= merge_lanes(mask1_q, wdat, wmask);
            end
            if (wr_en && reg_sel == REG_CTRL && wstrb[0]) begin
                ctrl_q <= wdata[CTRL_W-1:0];
            end
            // Set is ORed after the clear so a coincident edge is never lost
            stat0_q <= (stat0_q & ~clr0) | (edge0 & mask0_q);
            stat1_q <= (stat1_q & ~clr1) | (edge1 & mask1_q);
            irq     <= ctrl_q[CTRL_IRQ_EN] & (|(stat0_q | stat1_q));
        end
    end

    assign gpio_output = out_q;

endmodule
